// File: rtl/whirlpool_round_if.sv
// Handshake bundle between the round/key-schedule controller (master) and the
// iterative Whirlpool round engine (slave).
interface whirlpool_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] state_in;
    logic [511:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, key_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, key_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/whirlpool_round_iter.sv
// Iterative Whirlpool round: Pi, then gamma/theta (process_row), then Sigma,
// handling ROWS_PER_CYCLE rows of the 512-bit state per clock.
module whirlpool_round_iter #(
    parameter int unsigned ROWS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst_n,
    whirlpool_round_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [2:0] Step    = 3'(ROWS_PER_CYCLE % 8);
    localparam logic [2:0] LastCnt = 3'(8 - ROWS_PER_CYCLE);

    // Whirlpool mini-boxes E, E^-1 and R (nibble n at bits [63-4n -: 4]).
    localparam logic [63:0] EBox    = 64'h1B9CD6F3E874A250;
    localparam logic [63:0] EInvBox = 64'hF0D7BE5A92C13486;
    localparam logic [63:0] RBox    = 64'h7CBDE49F638A2510;
    // First row of the theta circulant: 01 01 04 01 08 05 02 09.
    localparam logic [31:0] CoefTab = 32'h11418529;

    if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 ||
          ROWS_PER_CYCLE == 4 || ROWS_PER_CYCLE == 8)) begin : g_bad_rpc
        $error("whirlpool_round_iter: ROWS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        a = EBox[63-4*int'(x[7:4]) -: 4];
        b = EInvBox[63-4*int'(x[3:0]) -: 4];
        r = RBox[63-4*int'(a ^ b) -: 4];
        return {EBox[63-4*int'(a ^ r) -: 4], EInvBox[63-4*int'(b ^ r) -: 4]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int b = 0; b < 4; b++) begin
            if (c[b]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [63:0] process_row(input logic [63:0] x);
        logic [7:0]  g [8];
        logic [7:0]  acc;
        logic [2:0]  ci;
        logic [63:0] t;
        t = '0;
        for (int j = 0; j < 8; j++) g[j] = sbox(x[63-8*j -: 8]);
        for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int k = 0; k < 8; k++) begin
                ci  = 3'(j - k);
                acc = acc ^ gf_mul(g[k], CoefTab[31-4*int'(ci) -: 4]);
            end
            t[63-8*j -: 8] = acc;
        end
        return t;
    endfunction

    // Column j of the state is rotated down by j rows.
    function automatic logic [63:0] pi_row(input logic [511:0] s, input logic [2:0] i);
        logic [63:0] r;
        logic [2:0]  src;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            src              = i - 3'(j);
            r[63-8*j -: 8]   = s[511-64*int'(src)-8*j -: 8];
        end
        return r;
    endfunction

    state_e       st_q, st_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [511:0] cap_q, cap_d;
    logic [511:0] key_q, key_d;
    logic [511:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            cnt_q       <= '0;
            cap_q       <= '0;
            key_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            key_q       <= key_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        key_d       = key_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        unique case (st_q)
            StIdle: begin
                if (bus.in_valid) begin
                    cap_d = bus.state_in;
                    key_d = bus.key_in;
                    cnt_d = '0;
                    st_d  = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < int'(ROWS_PER_CYCLE); k++) begin
                    out_d[511-64*int'(cnt_q + 3'(k)) -: 64] =
                        process_row(pi_row(cap_q, cnt_q + 3'(k))) ^
                        key_q[511-64*int'(cnt_q + 3'(k)) -: 64];
                end
                cnt_d = cnt_q + Step;
                if (cnt_q == LastCnt) begin
                    st_d        = StDone;
                    out_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    st_d        = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // in_ready is masked by reset so the controller never sees a ready engine in reset.
    assign bus.in_ready  = (st_q == StIdle) && rst_n;
    assign bus.busy      = (st_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.state_out = out_q;

endmodule

// File: tb/tb_whirlpool_round_iter.sv
// Directed bench: four engines (RPC = 1, 2, 4, 8) share one stimulus stream and
// are checked against a reference Whirlpool round and hand-computed vectors.
module tb_whirlpool_round_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] state_in;
    logic [511:0] key_in;

    logic [3:0]   ov;
    logic [3:0]   ir;
    logic [3:0]   bz;
    logic [511:0] so [4];

    int n_checks = 0;
    int n_fail   = 0;

    whirlpool_round_if bus1 ();
    whirlpool_round_if bus2 ();
    whirlpool_round_if bus4 ();
    whirlpool_round_if bus8 ();

    assign bus1.in_valid = in_valid;  assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid;  assign bus2.out_ready = out_ready;
    assign bus4.in_valid = in_valid;  assign bus4.out_ready = out_ready;
    assign bus8.in_valid = in_valid;  assign bus8.out_ready = out_ready;
    assign bus1.state_in = state_in;  assign bus1.key_in = key_in;
    assign bus2.state_in = state_in;  assign bus2.key_in = key_in;
    assign bus4.state_in = state_in;  assign bus4.key_in = key_in;
    assign bus8.state_in = state_in;  assign bus8.key_in = key_in;

    assign ov = {bus8.out_valid, bus4.out_valid, bus2.out_valid, bus1.out_valid};
    assign ir = {bus8.in_ready, bus4.in_ready, bus2.in_ready, bus1.in_ready};
    assign bz = {bus8.busy, bus4.busy, bus2.busy, bus1.busy};
    assign so[0] = bus1.state_out;
    assign so[1] = bus2.state_out;
    assign so[2] = bus4.state_out;
    assign so[3] = bus8.state_out;

    whirlpool_round_iter #(.ROWS_PER_CYCLE(1)) u_rpc1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    whirlpool_round_iter #(.ROWS_PER_CYCLE(2)) u_rpc2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    whirlpool_round_iter #(.ROWS_PER_CYCLE(4)) u_rpc4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    whirlpool_round_iter #(.ROWS_PER_CYCLE(8)) u_rpc8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    localparam logic [3:0] ETab [16] = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
                                         4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
    localparam logic [3:0] RTab [16] = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
                                         4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
    localparam logic [7:0] Circ [8]  = '{8'h01, 8'h01, 8'h04, 8'h01,
                                         8'h08, 8'h05, 8'h02, 8'h09};

    function automatic logic [3:0] e_inv(input logic [3:0] y);
        logic [3:0] r;
        r = '0;
        for (int v = 0; v < 16; v++) if (ETab[v] == y) r = 4'(v);
        return r;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [3:0] a, b, r;
        a = ETab[x[7:4]];
        b = e_inv(x[3:0]);
        r = RTab[a ^ b];
        return {ETab[a ^ r], e_inv(b ^ r)};
    endfunction

    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = '0;
        a = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [511:0] ref_round(input logic [511:0] st, input logic [511:0] key);
        logic [7:0]   a [8][8];
        logic [7:0]   p [8][8];
        logic [7:0]   acc;
        logic [511:0] res;
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) a[r][j] = st[511-64*r-8*j -: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) p[i][j] = ref_sbox(a[(i - j + 8) % 8][j]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int k = 0; k < 8; k++) acc ^= ref_mul(p[i][k], Circ[(j - k + 8) % 8]);
                res[511-64*i-8*j -: 8] = acc ^ key[511-64*i-8*j -: 8];
            end
        return res;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One round on all engines with out_ready low until every engine reports.
    task automatic do_round(input logic [511:0] st, input logic [511:0] key,
                            input logic [511:0] exp, input string tag);
        int lat [4];
        for (int n = 0; n < 4; n++) lat[n] = 0;
        @(negedge clk);
        state_in  = st;
        key_in    = key;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) if (ov[n] && lat[n] == 0) lat[n] = c;
        end
        for (int n = 0; n < 4; n++) begin
            check_val($sformatf("%s_lat_rpc%0d", tag, 1 << n), 512'(lat[n]), 512'(8 >> n));
            check_val($sformatf("%s_out_rpc%0d", tag, 1 << n), so[n], exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_ret_idle"}, 512'({ov, ir, bz}), 512'({4'h0, 4'hF, 4'h0}));
    endtask

    logic [511:0] st_v, key_v, exp_v;
    int           last_acc [4];
    int           n_acc    [4];
    int           period;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        key_in    = '0;
        #3;
        check_val("reset_flags", 512'({ov, ir, bz}), 512'(0));
        for (int n = 0; n < 4; n++) check_val($sformatf("reset_out_rpc%0d", 1 << n), so[n], '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_reset_ready", 512'(ir), 512'(4'hF));

        // Hand-computed: S(00)=18, theta gain 03 -> 28; XOR FF -> D7.
        do_round('0, '0, {64{8'h28}}, "zero_zero");
        do_round('0, {64{8'hFF}}, {64{8'hD7}}, "zero_ff");

        for (int r = 0; r < 8; r++) st_v[511-64*r -: 64] = {8{8'(r)}};
        do_round(st_v, '0, ref_round(st_v, '0), "pi_rows");

        for (int v = 0; v < 10; v++) begin
            st_v  = rand512();
            key_v = rand512();
            do_round(st_v, key_v, ref_round(st_v, key_v), $sformatf("rand%0d", v));
        end

        // Back-pressure: hold DONE for 20 cycles with a stray in_valid pulse.
        st_v  = rand512();
        key_v = rand512();
        exp_v = ref_round(st_v, key_v);
        @(negedge clk);
        state_in = st_v;
        key_in   = key_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                state_in = ~st_v;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check_val($sformatf("bp_flags_c%0d", c), 512'({ov, ir, bz}),
                      512'({4'hF, 4'h0, 4'hF}));
            for (int n = 0; n < 4; n++)
                check_val($sformatf("bp_out_c%0d_rpc%0d", c, 1 << n), so[n], exp_v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("bp_release", 512'({ov, ir, bz}), 512'({4'h0, 4'hF, 4'h0}));

        // Reset while the RPC=1 engine is at cnt=3 (others RUN or DONE).
        @(negedge clk);
        state_in = rand512();
        key_in   = rand512();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_flags", 512'({ov, ir, bz}), 512'(0));
        for (int n = 0; n < 4; n++) check_val($sformatf("rst_mid_out_rpc%0d", 1 << n), so[n], '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_release_ready", 512'(ir), 512'(4'hF));
        st_v  = rand512();
        key_v = rand512();
        do_round(st_v, key_v, ref_round(st_v, key_v), "after_rst");

        // Streaming: in_valid and out_ready held high.
        st_v  = rand512();
        key_v = rand512();
        exp_v = ref_round(st_v, key_v);
        for (int n = 0; n < 4; n++) begin
            last_acc[n] = -1;
            n_acc[n]    = 0;
        end
        @(negedge clk);
        state_in  = st_v;
        key_in    = key_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (ir[n]) begin
                    if (last_acc[n] >= 0)
                        check_val($sformatf("stream_gap_rpc%0d", 1 << n),
                                  512'(c - last_acc[n]), 512'((8 >> n) + 2));
                    last_acc[n] = c;
                    n_acc[n]++;
                end
                if (ov[n]) check_val($sformatf("stream_out_rpc%0d", 1 << n), so[n], exp_v);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            period = (8 >> n) + 2;
            check_val($sformatf("stream_count_rpc%0d", 1 << n), 512'(n_acc[n]),
                      512'(59 / period + 1));
        end
        repeat (12) @(negedge clk);
        out_ready = 1'b0;
        check_val("stream_drain_idle", 512'({ov, ir, bz}), 512'({4'h0, 4'hF, 4'h0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
